// File: rtl/citadel_uart_bridge.sv
// citadel_uart_bridge: byte-IO bridge between the citadel core and an 8N1 UART (TX FIFO + RX holding register).
// Optional macro CITADEL_UART_LOOPBACK_EN feeds the TX stream into the RX path and parks uart_txd high.
module citadel_uart_bridge #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       r_clk,
  input  logic       rst,
  input  logic [7:0] core_tx,
  input  logic       core_tx_ready,
  output logic [7:0] core_rx,
  output logic       core_rx_ready,
  input  logic       core_rx_ack,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       tx_overflow,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, tx_push, tx_pop;
  uart_state_t tx_state, tx_state_nxt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_pop     = (tx_state == S_IDLE) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign tx_push    = core_tx_ready && (!fifo_full || tx_pop);

  // NOTE: reset here is synchronous -- rst is only looked at on the clock edge.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (core_tx_ready && !tx_push) tx_overflow <= 1'b1;
    end
  end

  // NOTE: storage array is left unreset; pointers alone define what is valid.
  always_ff @(posedge r_clk) begin
    if (tx_push) fifo_mem[wr_ptr[AW-1:0]] <= core_tx;
  end

  // ---------------- TX FSM ----------------
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick, tx_serial;

  assign tx_tick = (tx_cnt == CW'(CLK_DIV - 1));

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
      else                               tx_cnt <= tx_cnt + CW'(1);
      if (tx_pop) begin
        tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
        tx_bit   <= '0;
      end else if (tx_state == S_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  // NOTE: defaulting every always_comb output first keeps latches from being inferred.
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:  if (!fifo_empty)                tx_state_nxt = S_START;
      S_START: if (tx_tick)                    tx_state_nxt = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == 3'd7)  tx_state_nxt = S_STOP;
      S_STOP:  if (tx_tick)                    tx_state_nxt = S_IDLE;
      default:                                 tx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_serial = 1'b1;
    case (tx_state)
      S_START: tx_serial = 1'b0;
      S_DATA:  tx_serial = tx_shift[0];
      default: tx_serial = 1'b1;
    endcase
  end

  // ---------------- Line routing ----------------
  logic rx_src;
`ifdef CITADEL_UART_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = uart_rxd;
  assign rx_src     = tx_serial;
  assign uart_txd   = 1'b1;
`else
  assign rx_src     = uart_rxd;
  assign uart_txd   = tx_serial;
`endif

  // ---------------- RX synchroniser ----------------
  logic rx_meta, rx_sync, rx_prev, rx_fall;

  always_ff @(posedge r_clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A fall needs the line seen high first, which also re-arms after a bad stop bit.
  assign rx_fall = rx_prev && !rx_sync;

  // ---------------- RX FSM ----------------
  uart_state_t   rx_state, rx_state_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_mid, rx_done, rx_bad_stop;

  assign rx_mid = (rx_cnt == CW'(1));

  always_ff @(posedge r_clk) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= CW'(CLK_DIV / 2);
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == S_IDLE) begin
        rx_cnt <= CW'(CLK_DIV / 2);
        rx_bit <= '0;
      end else if (rx_mid) begin
        rx_cnt <= CW'(CLK_DIV);
      end else begin
        rx_cnt <= rx_cnt - CW'(1);
      end
      if (rx_state == S_DATA && rx_mid) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall)                   rx_state_nxt = S_START;
      S_START: if (rx_mid)                    rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (rx_mid && rx_bit == 3'd7)  rx_state_nxt = S_STOP;
      S_STOP:  if (rx_mid)                    rx_state_nxt = S_IDLE;
      default:                                rx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done     = 1'b0;
    rx_bad_stop = 1'b0;
    if (rx_state == S_STOP && rx_mid) begin
      rx_done     = rx_sync;
      rx_bad_stop = !rx_sync;
    end
  end

  // ---------------- Holding register ----------------
  always_ff @(posedge r_clk) begin
    if (rst) begin
      core_rx       <= 8'h00;
      core_rx_ready <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      if (rx_bad_stop) rx_frame_err <= 1'b1;
      // An ack in the completion cycle frees the register for the new byte.
      if (rx_done && (!core_rx_ready || core_rx_ack)) begin
        core_rx       <= rx_shift;
        core_rx_ready <= 1'b1;
      end else begin
        if (rx_done)     rx_overrun    <= 1'b1;
        if (core_rx_ack) core_rx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_citadel_uart_bridge.sv
// tb_citadel_uart_bridge: directed/randomised bench for citadel_uart_bridge with CLK_DIV=8, FIFO_DEPTH=4.
// Expected values come from a queue model of the FIFO and the 8N1 frame definition.
module tb_citadel_uart_bridge;

  localparam int CLK_DIV    = 8;
  localparam int FIFO_DEPTH = 4;

  logic       r_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] core_tx = 8'h00;
  logic       core_tx_ready = 1'b0;
  logic [7:0] core_rx;
  logic       core_rx_ready;
  logic       core_rx_ack = 1'b0;
  logic       uart_txd;
  logic       uart_rxd = 1'b1;
  logic       tx_overflow, rx_overrun, rx_frame_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  citadel_uart_bridge #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .r_clk(r_clk), .rst(rst),
    .core_tx(core_tx), .core_tx_ready(core_tx_ready),
    .core_rx(core_rx), .core_rx_ready(core_rx_ready), .core_rx_ack(core_rx_ack),
    .uart_txd(uart_txd), .uart_rxd(uart_rxd),
    .tx_overflow(tx_overflow), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  always #5 r_clk = ~r_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All stimulus is driven and all outputs sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  // 8N1 line level for bit slot idx of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  // Decode one frame from uart_txd. in_start: the current sample is already start-bit cycle 0.
  task automatic collect_frame(input bit in_start, input int max_wait, output logic [7:0] d);
    int w = 0;
    d = 8'h00;
    if (!in_start) begin
      step(1);
      while (uart_txd !== 1'b0 && w < max_wait) begin
        step(1);
        w++;
      end
    end
    check("tx_start_edge", uart_txd, 1'b0);
    step(CLK_DIV / 2);
    check("tx_start_mid", uart_txd, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(CLK_DIV);
      d[i] = uart_txd;
    end
    step(CLK_DIV);
    check("tx_stop_mid", uart_txd, 1'b1);
  endtask

  task automatic send_serial(input logic [7:0] d, input logic stop_bit);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = (i == 9) ? stop_bit : frame_bit(d, i);
      step(CLK_DIV);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic wait_rx_ready();
    int w = 0;
    while (core_rx_ready !== 1'b1 && w < 3 * CLK_DIV) begin
      step(1);
      w++;
    end
    check("rx_ready_rise", core_rx_ready, 1'b1);
  endtask

  task automatic ack_pulse();
    core_rx_ack = 1'b1;
    step(1);
    core_rx_ack = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_txd"}, uart_txd, 1'b1);
    check({tag, "_core_rx"}, core_rx, 8'h00);
    check({tag, "_rx_ready"}, core_rx_ready, 1'b0);
    check({tag, "_tx_overflow"}, tx_overflow, 1'b0);
    check({tag, "_rx_overrun"}, rx_overrun, 1'b0);
    check({tag, "_rx_frame_err"}, rx_frame_err, 1'b0);
  endtask

  initial begin
    logic [7:0] burst [5];
    logic [7:0] c_byte, d, got;
    logic [7:0] model_q [$];
    logic [7:0] exp_sent [$];
    logic       exp_ovf, exp_txd;
    int         low_cnt, w;

    step(3);
    check_reset_values("reset");
    rst = 1'b0;
    step(2);

`ifdef CITADEL_UART_LOOPBACK_EN
    // Loopback: pushed byte returns on core_rx while the pin stays high.
    d = 8'($urandom);
    core_tx = d;
    core_tx_ready = 1'b1;
    step(1);
    core_tx_ready = 1'b0;
    low_cnt = 0;
    w = 0;
    while (core_rx_ready !== 1'b1 && w < 14 * CLK_DIV) begin
      step(1);
      if (uart_txd !== 1'b1) low_cnt++;
      w++;
    end
    check("lb_rx_ready", core_rx_ready, 1'b1);
    check("lb_core_rx", core_rx, d);
    check("lb_txd_low_cycles", low_cnt, 0);
    ack_pulse();
    check("lb_ack_clears", core_rx_ready, 1'b0);

    core_tx = 8'h5A;
    core_tx_ready = 1'b1;
    step(1);
    core_tx_ready = 1'b0;
    step(3 * CLK_DIV);
    rst = 1'b1;
    step(1);
    check_reset_values("lb_midframe_rst");
    rst = 1'b0;
    step(12 * CLK_DIV);
    check("lb_no_stray_rx", core_rx_ready, 1'b0);
`else
    // TX: A5 timed cycle by cycle, a 5-byte burst into a busy FIFO, then a push on the pop cycle.
    for (int i = 0; i < 5; i++) burst[i] = 8'($urandom);
    c_byte = 8'($urandom);
    exp_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (model_q.size() < FIFO_DEPTH) model_q.push_back(burst[i]);
      else exp_ovf = 1'b1;
    end
    exp_sent.push_back(model_q.pop_front());
    model_q.push_back(c_byte);
    while (model_q.size() > 0) exp_sent.push_back(model_q.pop_front());

    core_tx = 8'hA5;
    core_tx_ready = 1'b1;
    for (int t = 1; t <= 83; t++) begin
      step(1);
      core_tx_ready = 1'b0;
      if (t >= 10 && t <= 14) begin
        core_tx = burst[t-10];
        core_tx_ready = 1'b1;
      end
      if (t == 82) begin
        core_tx = c_byte;
        core_tx_ready = 1'b1;
      end
      if (t == 1 || t == 82) exp_txd = 1'b1;
      else if (t == 83)      exp_txd = 1'b0;
      else                   exp_txd = frame_bit(8'hA5, (t - 2) / CLK_DIV);
      check($sformatf("t1_txd_cycle%0d", t), uart_txd, exp_txd);
      if (t == 9)  check("tx_overflow_before", tx_overflow, 1'b0);
      if (t == 16) check("tx_overflow_after", tx_overflow, exp_ovf);
    end
    core_tx_ready = 1'b0;

    for (int f = 0; f < exp_sent.size(); f++) begin
      collect_frame(f == 0, 4, got);
      check($sformatf("tx_frame%0d_byte", f), got, exp_sent[f]);
    end
    step(3 * CLK_DIV);
    check("tx_idle_after", uart_txd, 1'b1);

    // RX: 3C, ack clears ready, stray ack ignored.
    step(4);
    send_serial(8'h3C, 1'b1);
    wait_rx_ready();
    check("t3_core_rx", core_rx, 8'h3C);
    ack_pulse();
    check("t3_ack_clears", core_rx_ready, 1'b0);
    ack_pulse();
    step(1);
    check("t3_stray_ack_ready", core_rx_ready, 1'b0);
    check("t3_stray_ack_data", core_rx, 8'h3C);

    // RX: random bytes with a random hold before ack.
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      step(2);
      send_serial(d, 1'b1);
      wait_rx_ready();
      step($urandom_range(0, 5));
      check($sformatf("rx_rand%0d_byte", k), core_rx, d);
      check($sformatf("rx_rand%0d_ready", k), core_rx_ready, 1'b1);
      check($sformatf("rx_rand%0d_overrun", k), rx_overrun, 1'b0);
      ack_pulse();
      check($sformatf("rx_rand%0d_ack", k), core_rx_ready, 1'b0);
    end

    // RX overrun: 11 unread, then 22 arrives.
    step(2);
    send_serial(8'h11, 1'b1);
    wait_rx_ready();
    step(2);
    send_serial(8'h22, 1'b1);
    step(4);
    check("t4_core_rx_kept", core_rx, 8'h11);
    check("t4_ready_kept", core_rx_ready, 1'b1);
    check("t4_overrun", rx_overrun, 1'b1);
    ack_pulse();
    check("t4_ack_clears", core_rx_ready, 1'b0);

    // RX framing error then a 2-cycle glitch, then a clean byte.
    step(2);
    send_serial(8'($urandom), 1'b0);
    step(4);
    check("t5_frame_err", rx_frame_err, 1'b1);
    check("t5_no_ready_bad_stop", core_rx_ready, 1'b0);
    uart_rxd = 1'b0;
    step(2);
    uart_rxd = 1'b1;
    step(3 * CLK_DIV);
    check("t5_glitch_ignored", core_rx_ready, 1'b0);
    d = 8'($urandom);
    send_serial(d, 1'b1);
    wait_rx_ready();
    check("t5_rearm_byte", core_rx, d);
    check("t5_overrun_sticky", rx_overrun, 1'b1);
    ack_pulse();

    // Reset mid-frame with a byte still queued: line high at once, nothing sent afterwards.
    step(2);
    core_tx = 8'($urandom);
    core_tx_ready = 1'b1;
    step(1);
    core_tx = 8'($urandom);
    step(1);
    core_tx_ready = 1'b0;
    step(3 * CLK_DIV);
    rst = 1'b1;
    step(1);
    check_reset_values("midframe_rst");
    rst = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 12 * CLK_DIV; i++) begin
      step(1);
      if (uart_txd !== 1'b1) low_cnt++;
    end
    check("rst_fifo_flushed", low_cnt, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
